rom_read_arbiter: RTL and testbench
===================================

Name: rom_read_arbiter

Overview:
Round-robin arbiter and sequencer that shares one synchronous ROM read port among NUM_REQ requesters. It accepts one request at a time using a valid/ready handshake and drives the ROM enable/address. It tracks the ROM's one-cycle registered read latency, then holds the returned word for the winning requester until that requester accepts it. It sits between client blocks (fetch, table lookup, config loader) and the rom_memory instance.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ADDR_WIDTH, 8, ROM address width
DATA_WIDTH, 32, ROM data width

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  NUM_REQ  per-requester read request
req_addr  input  NUM_REQ*ADDR_WIDTH  packed addresses; requester i uses bits [i*ADDR_WIDTH +: ADDR_WIDTH]
req_ready  output  NUM_REQ  one-hot request accept
rsp_valid  output  NUM_REQ  one-hot response valid, to granted requester only
rsp_ready  input  NUM_REQ  per-requester response accept
rsp_data  output  DATA_WIDTH  response word, shared by all requesters
rom_enable  output  1  to ROM enable
rom_addr  output  ADDR_WIDTH  to ROM addr
rom_data  input  DATA_WIDTH  from ROM data_out; registered, 1-cycle latency, Z when disabled

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE; req_ready=0, rsp_valid=0, rsp_data=0, rom_enable=0, rom_addr=0.
  - Round-robin pointer last_grant=NUM_REQ-1, so requester 0 has highest priority first.
- FSM states: IDLE, ISSUE, CAPTURE, RESP.
- IDLE:
  - Combinationally select winner w: the first i with req_valid[i]=1, scanning from last_grant+1 upward with wrap modulo NUM_REQ.
  - req_ready[w]=1 (all other bits 0); req_ready is 0 when no req_valid bit is set.
  - On the edge where req_valid[w]&&req_ready[w]: latch addr_q=req_addr[w], id_q=w, last_grant=w; go to ISSUE.
  - req_ready is asserted only in IDLE.
- ISSUE (1 cycle): rom_enable=1, rom_addr=addr_q; go to CAPTURE.
- CAPTURE (1 cycle):
  - rom_enable=0; rom_addr holds addr_q.
  - At the end of this cycle, register rsp_data<=rom_data; go to RESP.
  - rom_data is sampled in no other state, so Z values never reach rsp_data.
- RESP:
  - rsp_valid[id_q]=1; rsp_data held stable.
  - When rsp_ready[id_q]=1, go to IDLE on that edge; rsp_valid drops the next cycle.
  - rsp_ready bits of non-granted requesters are ignored.
- Latency: accept edge E0, then ROM enable in cycle E0+1, then rsp_valid from cycle E0+3.
- Throughput: minimum 4 cycles per read with rsp_ready held high. No new request is accepted until the response handshake completes (single outstanding).
- rsp_data keeps its last value outside RESP. rsp_valid, req_ready and rom_enable are registered or state-decoded and glitch-free per state.
- Requester drops req_valid before grant: no effect; arbitration is re-evaluated each IDLE cycle.
- Reset mid-operation (any state): abort immediately to reset values; no response is delivered; the pointer returns to NUM_REQ-1.
- Idle with no requests: outputs stay at reset-equivalent values except rsp_data and last_grant.

Test Plan:
- ROM[0]=32'hDEADBEEF; requester 0 pulses req_valid with addr 0, rsp_ready=1 -> req_ready[0] at cycle 0, rom_enable=1 with rom_addr=0 at cycle 1, rsp_valid=4'b0001 with rsp_data=32'hDEADBEEF at cycle 3, one cycle long.
- All 4 requesters continuously valid, addrs 0,1,2,0 -> grant order 0,1,2,3,0,1. Responses DEADBEEF, 12345678, ABCDEF01, DEADBEEF, each 4 cycles apart.
- Requester 1 served; then requesters 0 and 2 both valid -> requester 2 granted first, then 0.
- Requester 2 reads addr 1 with rsp_ready[2] low 5 cycles (rsp_ready[0] high meanwhile) -> rsp_valid[2] and rsp_data=32'h12345678 held 5+ cycles; no req_ready asserted; completes when rsp_ready[2] rises.
- rst_n asserted during CAPTURE -> all outputs 0 without waiting for a clock edge; after release, requester 3 and 0 both valid -> requester 0 granted first.
- Addr 200 (uninitialised ROM, X) -> rsp_data X-propagation only in RESP. rom_data driven Z in IDLE/ISSUE never captured; rsp_data retains its previous value.

Source files
------------

// File: rtl/rom_read_arbiter_if.sv
// Request/response bundle between the client blocks and rom_read_arbiter.
// master = requester side, slave = arbiter side.
interface rom_read_arbiter_if #(
   parameter int unsigned NUM_REQ    = 4,
   parameter int unsigned ADDR_WIDTH = 8,
   parameter int unsigned DATA_WIDTH = 32
);
   logic [NUM_REQ-1:0]            req_valid;
   logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
   logic [NUM_REQ-1:0]            req_ready;
   logic [NUM_REQ-1:0]            rsp_valid;
   logic [NUM_REQ-1:0]            rsp_ready;
   logic [DATA_WIDTH-1:0]         rsp_data;

   modport master (
      output req_valid, req_addr, rsp_ready,
      input  req_ready, rsp_valid, rsp_data
   );

   modport slave (
      input  req_valid, req_addr, rsp_ready,
      output req_ready, rsp_valid, rsp_data
   );
endinterface

// File: rtl/rom_read_arbiter.sv
// Round-robin arbiter sharing one synchronous ROM read port among NUM_REQ
// requesters; single outstanding read, response held until accepted.
module rom_read_arbiter #(
   parameter int unsigned NUM_REQ    = 4,
   parameter int unsigned ADDR_WIDTH = 8,
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   rom_read_arbiter_if.slave     bus,
   output logic                  rom_enable,
   output logic [ADDR_WIDTH-1:0] rom_addr,
   input  logic [DATA_WIDTH-1:0] rom_data
);
   localparam int unsigned ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;

   state_t                state, state_d;
   logic [ID_W-1:0]       last_grant, id_q, win;
   logic                  found;
   logic [NUM_REQ-1:0]    req_ready_c;
   logic [NUM_REQ-1:0]    rsp_valid_q, rsp_valid_d;
   logic [DATA_WIDTH-1:0] rsp_data_q;
   logic                  rom_enable_d;
   logic [ADDR_WIDTH-1:0] rom_addr_d;
   logic                  load, capture;
   logic [ADDR_WIDTH-1:0] addr_arr [NUM_REQ];

   for (genvar i = 0; i < NUM_REQ; i++) begin : g_addr
      assign addr_arr[i] = bus.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
   end

   // Round-robin winner: scanning downward so the closest index after last_grant wins.
   always_comb begin
      int idx;
      found = 1'b0;
      win   = '0;
      idx   = 0;
      for (int k = int'(NUM_REQ); k > 0; k--) begin
         idx = int'(last_grant) + k;
         if (idx >= int'(NUM_REQ)) idx = idx - int'(NUM_REQ);
         if (bus.req_valid[ID_W'(idx)]) begin
            found = 1'b1;
            win   = ID_W'(idx);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_d;
   end

   // Next state and next values of the registered ROM/response outputs.
   always_comb begin
      state_d      = state;
      req_ready_c  = '0;
      rom_enable_d = 1'b0;
      rom_addr_d   = rom_addr;
      rsp_valid_d  = rsp_valid_q;
      load         = 1'b0;
      capture      = 1'b0;
      case (state)
         IDLE: begin
            if (found) begin
               req_ready_c  = NUM_REQ'(1) << win;
               state_d      = ISSUE;
               rom_enable_d = 1'b1;
               rom_addr_d   = addr_arr[win];
               load         = 1'b1;
            end
         end
         ISSUE: begin
            state_d = CAPTURE;
         end
         CAPTURE: begin
            state_d     = RESP;
            capture     = 1'b1;
            rom_addr_d  = '0;
            rsp_valid_d = NUM_REQ'(1) << id_q;
         end
         RESP: begin
            if (bus.rsp_ready[id_q]) begin
               state_d     = IDLE;
               rsp_valid_d = '0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rom_enable  <= 1'b0;
         rom_addr    <= '0;
         rsp_valid_q <= '0;
         rsp_data_q  <= '0;
         last_grant  <= ID_W'(NUM_REQ - 1);
         id_q        <= '0;
      end else begin
         rom_enable  <= rom_enable_d;
         rom_addr    <= rom_addr_d;
         rsp_valid_q <= rsp_valid_d;
         if (load) begin
            last_grant <= win;
            id_q       <= win;
         end
         // rom_data is only sampled here, after the ROM's one-cycle latency.
         if (capture) rsp_data_q <= rom_data;
      end
   end

   assign bus.req_ready = req_ready_c;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_data  = rsp_data_q;
endmodule

// File: tb/tb_rom_read_arbiter.sv
// Self-checking bench for rom_read_arbiter: behavioural ROM, round-robin
// reference model with a response scoreboard, plus per-scenario timing checks.
module tb_rom_read_arbiter;
   localparam int unsigned NR = 4;
   localparam int unsigned AW = 8;
   localparam int unsigned DW = 32;

   typedef struct {
      int            id;
      logic [DW-1:0] data;
   } exp_t;

   logic          clk;
   logic          rst_n;
   logic          rom_enable;
   logic [AW-1:0] rom_addr;
   wire  [DW-1:0] rom_data;

   logic [DW-1:0] mem [256];
   logic [DW-1:0] rom_q;
   logic          rom_en_q;

   int   n_cmp;
   int   n_fail;
   exp_t sb[$];
   bit   m_busy;
   int   m_last;

   rom_read_arbiter_if #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

   rom_read_arbiter #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .bus        (bus.slave),
      .rom_enable (rom_enable),
      .rom_addr   (rom_addr),
      .rom_data   (rom_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous ROM: registered read, output floats when not enabled.
   always @(posedge clk) begin
      rom_en_q <= rom_enable;
      rom_q    <= mem[rom_addr];
   end
   assign rom_data = rom_en_q ? rom_q : 'z;

   // Reference model: expected grant each cycle, scoreboard of responses.
   always @(negedge clk) begin
      logic [NR-1:0] exp_rdy;
      int            w;
      logic [AW-1:0] a;
      exp_t          e;
      if (!rst_n) begin
         m_busy = 1'b0;
         m_last = NR - 1;
         sb.delete();
      end else begin
         exp_rdy = '0;
         w = -1;
         if (!m_busy) begin
            for (int k = 1; k <= NR; k++) begin
               if (w < 0 && bus.req_valid[(m_last + k) % NR]) w = (m_last + k) % NR;
            end
            if (w >= 0) exp_rdy[w] = 1'b1;
         end
         n_cmp++;
         if (bus.req_ready !== exp_rdy) begin
            n_fail++;
            $display("FAIL model_req_ready: got %b want %b at %0t", bus.req_ready, exp_rdy, $time);
         end
         if (w >= 0) begin
            a      = bus.req_addr[w*AW +: AW];
            e.id   = w;
            e.data = mem[a];
            sb.push_back(e);
            m_busy = 1'b1;
            m_last = w;
         end
         if (bus.rsp_valid !== '0) begin
            n_cmp++;
            if (sb.size() == 0) begin
               n_fail++;
               $display("FAIL model_rsp_unexpected: got rsp_valid %b want 0000 at %0t", bus.rsp_valid, $time);
            end else begin
               e = sb[0];
               exp_rdy = '0;
               exp_rdy[e.id] = 1'b1;
               if (bus.rsp_valid !== exp_rdy) begin
                  n_fail++;
                  $display("FAIL model_rsp_valid: got %b want %b at %0t", bus.rsp_valid, exp_rdy, $time);
               end
               n_cmp++;
               if (bus.rsp_data !== e.data) begin
                  n_fail++;
                  $display("FAIL model_rsp_data: got %h want %h at %0t", bus.rsp_data, e.data, $time);
               end
               if (bus.rsp_ready[e.id]) begin
                  void'(sb.pop_front());
                  m_busy = 1'b0;
               end
            end
         end
      end
   end

   task automatic do_reset();
      bus.req_valid = '0;
      rst_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic drain();
      int t = 0;
      @(negedge clk); #1;
      while ((m_busy || sb.size() != 0) && t < 40) begin
         @(negedge clk); #1;
         t++;
      end
      n_cmp++;
      if (m_busy || sb.size() != 0) begin
         n_fail++;
         $display("FAIL drain_timeout: got %0d pending want 0", sb.size());
      end
   endtask

   task automatic wait_grant(input string name, input logic [NR-1:0] want);
      int t = 0;
      @(negedge clk);
      while (bus.req_ready === '0 && t < 30) begin
         @(negedge clk);
         t++;
      end
      n_cmp++;
      if (bus.req_ready !== want) begin
         n_fail++;
         $display("FAIL %s: got req_ready %b want %b", name, bus.req_ready, want);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b1;
      bus.req_valid = '0;
      bus.req_addr  = '0;
      bus.rsp_ready = '0;
      #2 rst_n = 1'b0;
      #2;
      n_cmp += 5;
      if (bus.req_ready !== '0) begin n_fail++; $display("FAIL reset_req_ready: got %b want 0000", bus.req_ready); end
      if (bus.rsp_valid !== '0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b want 0000", bus.rsp_valid); end
      if (bus.rsp_data !== '0)  begin n_fail++; $display("FAIL reset_rsp_data: got %h want 0", bus.rsp_data); end
      if (rom_enable !== 1'b0)  begin n_fail++; $display("FAIL reset_rom_enable: got %b want 0", rom_enable); end
      if (rom_addr !== '0)      begin n_fail++; $display("FAIL reset_rom_addr: got %h want 0", rom_addr); end
      @(negedge clk);
      @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic test_single();
      bus.rsp_ready = '1;
      bus.req_addr  = '0;
      @(posedge clk); #1;
      bus.req_valid = 4'b0001;
      @(negedge clk);
      n_cmp++;
      if (bus.req_ready !== 4'b0001) begin n_fail++; $display("FAIL single_c0_ready: got %b want 0001", bus.req_ready); end
      @(posedge clk); #1;
      bus.req_valid = '0;
      @(negedge clk);
      n_cmp += 2;
      if (rom_enable !== 1'b1) begin n_fail++; $display("FAIL single_c1_enable: got %b want 1", rom_enable); end
      if (rom_addr !== 8'd0)   begin n_fail++; $display("FAIL single_c1_addr: got %h want 00", rom_addr); end
      @(negedge clk);
      n_cmp++;
      if (rom_enable !== 1'b0) begin n_fail++; $display("FAIL single_c2_enable: got %b want 0", rom_enable); end
      @(negedge clk);
      n_cmp += 2;
      if (bus.rsp_valid !== 4'b0001)   begin n_fail++; $display("FAIL single_c3_valid: got %b want 0001", bus.rsp_valid); end
      if (bus.rsp_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL single_c3_data: got %h want deadbeef", bus.rsp_data); end
      @(negedge clk);
      n_cmp++;
      if (bus.rsp_valid !== 4'b0000) begin n_fail++; $display("FAIL single_c4_valid: got %b want 0000", bus.rsp_valid); end
      drain();
   endtask

   task automatic test_round_robin();
      int order [6] = '{0, 1, 2, 3, 0, 1};
      int cyc = 0;
      int last_cyc = 0;
      int t;
      logic [NR-1:0] want;
      do_reset();
      bus.rsp_ready = '1;
      bus.req_addr  = {8'd0, 8'd2, 8'd1, 8'd0};
      bus.req_valid = 4'b1111;
      @(negedge clk);
      for (int g = 0; g < 6; g++) begin
         t = 0;
         while (bus.req_ready === '0 && t < 20) begin
            @(negedge clk);
            cyc++;
            t++;
         end
         want = '0;
         want[order[g]] = 1'b1;
         n_cmp++;
         if (bus.req_ready !== want) begin
            n_fail++;
            $display("FAIL rr_grant%0d: got %b want %b", g, bus.req_ready, want);
         end
         if (g > 0) begin
            n_cmp++;
            if (cyc - last_cyc != 4) begin
               n_fail++;
               $display("FAIL rr_spacing%0d: got %0d cycles want 4", g, cyc - last_cyc);
            end
         end
         last_cyc = cyc;
         if (g < 5) begin
            @(negedge clk);
            cyc++;
         end
      end
      @(posedge clk); #1;
      bus.req_valid = '0;
      drain();
   endtask

   task automatic test_priority_rotation();
      do_reset();
      bus.rsp_ready = '1;
      bus.req_addr  = {8'd0, 8'd1, 8'd2, 8'd0};
      bus.req_valid = 4'b0010;
      wait_grant("rot_first_req1", 4'b0010);
      @(posedge clk); #1;
      bus.req_valid = '0;
      drain();
      bus.req_valid = 4'b0101;
      wait_grant("rot_req2_before_req0", 4'b0100);
      @(posedge clk); #1;
      bus.req_valid = 4'b0001;
      wait_grant("rot_req0_after_req2", 4'b0001);
      @(posedge clk); #1;
      bus.req_valid = '0;
      drain();
   endtask

   task automatic test_backpressure();
      int t = 0;
      bus.req_addr  = {8'd0, 8'd1, 8'd0, 8'd0};
      bus.rsp_ready = 4'b1011;
      bus.req_valid = 4'b0100;
      wait_grant("bp_grant_req2", 4'b0100);
      @(posedge clk); #1;
      bus.req_valid = 4'b0001;
      @(negedge clk);
      while (bus.rsp_valid === '0 && t < 10) begin
         @(negedge clk);
         t++;
      end
      for (int i = 0; i < 6; i++) begin
         n_cmp += 3;
         if (bus.rsp_valid !== 4'b0100)     begin n_fail++; $display("FAIL bp_hold_valid%0d: got %b want 0100", i, bus.rsp_valid); end
         if (bus.rsp_data !== 32'h12345678) begin n_fail++; $display("FAIL bp_hold_data%0d: got %h want 12345678", i, bus.rsp_data); end
         if (bus.req_ready !== 4'b0000)     begin n_fail++; $display("FAIL bp_no_ready%0d: got %b want 0000", i, bus.req_ready); end
         if (i < 5) @(negedge clk);
      end
      @(posedge clk); #1;
      bus.rsp_ready = '1;
      @(negedge clk);
      n_cmp++;
      if (bus.rsp_valid !== 4'b0100) begin n_fail++; $display("FAIL bp_last_valid: got %b want 0100", bus.rsp_valid); end
      @(negedge clk);
      n_cmp += 2;
      if (bus.rsp_valid !== 4'b0000) begin n_fail++; $display("FAIL bp_done_valid: got %b want 0000", bus.rsp_valid); end
      if (bus.req_ready !== 4'b0001) begin n_fail++; $display("FAIL bp_next_grant: got %b want 0001", bus.req_ready); end
      @(posedge clk); #1;
      bus.req_valid = '0;
      drain();
   endtask

   task automatic test_reset_mid();
      bus.rsp_ready = '1;
      bus.req_addr  = {8'd2, 8'd0, 8'd1, 8'd0};
      bus.req_valid = 4'b0010;
      wait_grant("rstmid_grant_req1", 4'b0010);
      @(posedge clk); #1;
      bus.req_valid = '0;
      @(negedge clk);
      n_cmp += 2;
      if (rom_enable !== 1'b1) begin n_fail++; $display("FAIL rstmid_issue_enable: got %b want 1", rom_enable); end
      if (rom_addr !== 8'd1)   begin n_fail++; $display("FAIL rstmid_issue_addr: got %h want 01", rom_addr); end
      @(negedge clk);
      #1 rst_n = 1'b0;
      #1;
      n_cmp += 5;
      if (bus.req_ready !== '0) begin n_fail++; $display("FAIL rstmid_req_ready: got %b want 0000", bus.req_ready); end
      if (bus.rsp_valid !== '0) begin n_fail++; $display("FAIL rstmid_rsp_valid: got %b want 0000", bus.rsp_valid); end
      if (bus.rsp_data !== '0)  begin n_fail++; $display("FAIL rstmid_rsp_data: got %h want 0", bus.rsp_data); end
      if (rom_enable !== 1'b0)  begin n_fail++; $display("FAIL rstmid_rom_enable: got %b want 0", rom_enable); end
      if (rom_addr !== '0)      begin n_fail++; $display("FAIL rstmid_rom_addr: got %h want 0", rom_addr); end
      @(negedge clk);
      @(negedge clk);
      @(posedge clk); #1;
      rst_n = 1'b1;
      bus.req_valid = 4'b1001;
      @(negedge clk);
      n_cmp++;
      if (bus.req_ready !== 4'b0001) begin n_fail++; $display("FAIL rstmid_ptr_req0_first: got %b want 0001", bus.req_ready); end
      @(posedge clk); #1;
      bus.req_valid = 4'b1000;
      wait_grant("rstmid_then_req3", 4'b1000);
      @(posedge clk); #1;
      bus.req_valid = '0;
      drain();
   endtask

   task automatic test_z_and_x();
      bus.rsp_ready = '1;
      bus.req_addr  = {8'd0, 8'd0, 8'd1, 8'd0};
      bus.req_valid = 4'b0010;
      wait_grant("zx_grant_req1", 4'b0010);
      @(posedge clk); #1;
      bus.req_valid = '0;
      drain();
      n_cmp++;
      if (bus.rsp_data !== 32'h12345678) begin n_fail++; $display("FAIL zx_idle_retain: got %h want 12345678", bus.rsp_data); end
      bus.req_addr  = {8'd0, 8'd0, 8'd1, 8'd200};
      bus.req_valid = 4'b0001;
      wait_grant("zx_grant_req0", 4'b0001);
      @(posedge clk); #1;
      bus.req_valid = '0;
      @(negedge clk);
      n_cmp++;
      if (bus.rsp_data !== 32'h12345678) begin n_fail++; $display("FAIL zx_issue_retain: got %h want 12345678", bus.rsp_data); end
      @(negedge clk);
      n_cmp++;
      if (bus.rsp_data !== 32'h12345678) begin n_fail++; $display("FAIL zx_capture_retain: got %h want 12345678", bus.rsp_data); end
      drain();
   endtask

   initial begin
      n_cmp  = 0;
      n_fail = 0;
      m_busy = 1'b0;
      m_last = NR - 1;
      mem[0] = 32'hDEADBEEF;
      mem[1] = 32'h12345678;
      mem[2] = 32'hABCDEF01;
      test_reset();
      test_single();
      test_round_robin();
      test_priority_rotation();
      test_backpressure();
      test_reset_mid();
      test_z_and_x();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
